// File: rtl/uart_alu_if_if.sv
// Bundle between uart_alu_if and its neighbours: receiver, ALU and transmitter.
// slave is the uart_alu_if side. master is the side that drives the stimulus.
interface uart_alu_if_if #(
  parameter int NB_DATA = 8,
  parameter int NB_OP   = 6
);
  logic [NB_DATA-1:0] i_rx_data;
  logic               i_rx_done;
  logic [NB_DATA-1:0] o_alu_a;
  logic [NB_DATA-1:0] o_alu_b;
  logic [NB_OP-1:0]   o_alu_op;
  logic [NB_DATA-1:0] i_alu_result;
  logic [NB_DATA-1:0] o_tx_data;
  logic               o_tx_start;
  logic               i_tx_done;
  logic               o_busy;
  logic               o_overrun;
  logic               o_timeout;

  modport slave (
    input  i_rx_data, i_rx_done, i_alu_result, i_tx_done,
    output o_alu_a, o_alu_b, o_alu_op, o_tx_data, o_tx_start,
           o_busy, o_overrun, o_timeout
  );

  modport master (
    output i_rx_data, i_rx_done, i_alu_result, i_tx_done,
    input  o_alu_a, o_alu_b, o_alu_op, o_tx_data, o_tx_start,
           o_busy, o_overrun, o_timeout
  );
endinterface

// File: rtl/uart_alu_if.sv
// Builds an ALU command from three UART bytes (A, B, opcode) and sends the result back to the transmitter.
// The optional inter-byte timeout is enabled with the RX_TIMEOUT_EN macro.
module uart_alu_if #(
  parameter int NB_DATA        = 8,
  parameter int NB_OP          = 6,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic           clk,
  input  logic           i_rst,
  uart_alu_if_if.slave   bus
);
  localparam logic [2:0] WAIT_A  = 3'd0;
  localparam logic [2:0] WAIT_B  = 3'd1;
  localparam logic [2:0] WAIT_OP = 3'd2;
  localparam logic [2:0] EXEC    = 3'd3;
  localparam logic [2:0] SEND    = 3'd4;
  localparam logic [2:0] WAIT_TX = 3'd5;

  logic [2:0]         state;
  logic               rx_done_d;
  logic               tx_done_d;
  logic               rx_evt;
  logic               tx_evt;
  logic               busy;
  logic               tmo_hit;
  logic [NB_DATA-1:0] alu_a;
  logic [NB_DATA-1:0] alu_b;
  logic [NB_OP-1:0]   alu_op;
  logic [NB_DATA-1:0] tx_data;
  logic               tx_start;
  logic               overrun;

  assign rx_evt = bus.i_rx_done & ~rx_done_d;
  assign tx_evt = bus.i_tx_done & ~tx_done_d;
  assign busy   = (state == EXEC) || (state == SEND) || (state == WAIT_TX);

`ifdef RX_TIMEOUT_EN
  localparam int NB_CNT = $clog2(TIMEOUT_CYCLES + 1);

  logic [NB_CNT-1:0] tmo_cnt;
  logic              timeout;

  // Same-cycle rx_evt beats expiry, so the byte is kept and no timeout is raised.
  assign tmo_hit = ((state == WAIT_B) || (state == WAIT_OP)) && !rx_evt &&
                   (tmo_cnt == NB_CNT'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (i_rst) begin
      tmo_cnt <= '0;
      timeout <= 1'b0;
    end else begin
      timeout <= tmo_hit;
      if (((state != WAIT_B) && (state != WAIT_OP)) || rx_evt || tmo_hit)
        tmo_cnt <= '0;
      else
        tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  assign bus.o_timeout = timeout;
`else
  assign tmo_hit       = 1'b0;
  assign bus.o_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state     <= WAIT_A;
      rx_done_d <= 1'b0;
      tx_done_d <= 1'b0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
      tx_data   <= '0;
      tx_start  <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      rx_done_d <= bus.i_rx_done;
      tx_done_d <= bus.i_tx_done;
      tx_start  <= 1'b0;
      if (rx_evt && busy)
        overrun <= 1'b1;
      case (state)
        WAIT_A: begin
          if (rx_evt) begin
            alu_a <= bus.i_rx_data;
            state <= WAIT_B;
          end
        end
        WAIT_B: begin
          if (rx_evt) begin
            alu_b <= bus.i_rx_data;
            state <= WAIT_OP;
          end else if (tmo_hit) begin
            state <= WAIT_A;
          end
        end
        WAIT_OP: begin
          if (rx_evt) begin
            alu_op <= bus.i_rx_data[NB_OP-1:0];
            state  <= EXEC;
          end else if (tmo_hit) begin
            state <= WAIT_A;
          end
        end
        // Start is set here so it is high exactly during SEND.
        EXEC: begin
          tx_data  <= bus.i_alu_result;
          tx_start <= 1'b1;
          state    <= SEND;
        end
        SEND: begin
          state <= WAIT_TX;
        end
        WAIT_TX: begin
          if (tx_evt)
            state <= WAIT_A;
        end
        default: begin
          state <= WAIT_A;
        end
      endcase
    end
  end

  assign bus.o_alu_a    = alu_a;
  assign bus.o_alu_b    = alu_b;
  assign bus.o_alu_op   = alu_op;
  assign bus.o_tx_data  = tx_data;
  assign bus.o_tx_start = tx_start;
  assign bus.o_busy     = busy;
  assign bus.o_overrun  = overrun;
endmodule

// File: tb/tb_uart_alu_if.sv
// Self-checking bench for uart_alu_if: vector table plus hand-written corner sequences, scoreboarded tx results.
module tb_uart_alu_if;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  logic [7:0] exp_q[$];

  uart_alu_if_if #(.NB_DATA(8), .NB_OP(6)) bus ();

  uart_alu_if #(.NB_DATA(8), .NB_OP(6), .TIMEOUT_CYCLES(16)) dut (
    .clk  (clk),
    .i_rst(rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                           input logic [5:0] op);
    case (op)
      6'h20:   return a + b;
      6'h22:   return a - b;
      6'h24:   return a & b;
      6'h25:   return a | b;
      6'h26:   return a ^ b;
      6'h27:   return ~(a | b);
      6'h03:   return $signed(a) >>> b;
      6'h02:   return a >> b;
      default: return 8'h00;
    endcase
  endfunction

  always_comb bus.i_alu_result = alu_model(bus.o_alu_a, bus.o_alu_b, bus.o_alu_op);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every transmit start must carry the oldest pending expected result.
  always @(negedge clk) begin
    if (bus.o_tx_start === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected_start: got tx_data %0h expected no start", bus.o_tx_data);
      end else begin
        check("sb_tx_data", {24'h0, bus.o_tx_data}, {24'h0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.i_rx_data = b;
    bus.i_rx_done = 1'b1;
    @(negedge clk);
    bus.i_rx_done = 1'b0;
  endtask

  // Entered one negedge after the opcode rx_done rise.
  task automatic expect_tx(input string tag);
    check({tag, "_busy_exec"}, {31'h0, bus.o_busy}, 32'h1);
    check({tag, "_start_early"}, {31'h0, bus.o_tx_start}, 32'h0);
    @(negedge clk);
    check({tag, "_start_lat"}, {31'h0, bus.o_tx_start}, 32'h1);
    @(negedge clk);
    check({tag, "_start_width"}, {31'h0, bus.o_tx_start}, 32'h0);
    check({tag, "_busy_wait"}, {31'h0, bus.o_busy}, 32'h1);
    bus.i_tx_done = 1'b1;
    @(negedge clk);
    bus.i_tx_done = 1'b0;
    check({tag, "_busy_done"}, {31'h0, bus.o_busy}, 32'h0);
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] op_byte;
    logic [5:0] exp_op;
    logic [7:0] exp_res;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int pulses;
    vecs[0] = '{8'h05, 8'h03, 8'h20, 6'h20, 8'h08};
    vecs[1] = '{8'h0A, 8'h03, 8'hE2, 6'h22, 8'h07};
    vecs[2] = '{8'hF0, 8'h3C, 8'h24, 6'h24, 8'h30};
    vecs[3] = '{8'hF0, 8'h0F, 8'h25, 6'h25, 8'hFF};
    vecs[4] = '{8'hAA, 8'hFF, 8'h26, 6'h26, 8'h55};
    vecs[5] = '{8'h81, 8'h02, 8'h03, 6'h03, 8'hE0};
    vecs[6] = '{8'h80, 8'h03, 8'h02, 6'h02, 8'h10};
    vecs[7] = '{8'h00, 8'h00, 8'h27, 6'h27, 8'hFF};

    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.i_rx_data = 8'h00;
    bus.i_rx_done = 1'b0;
    bus.i_tx_done = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_alu_a", {24'h0, bus.o_alu_a}, 32'h0);
    check("rst_alu_b", {24'h0, bus.o_alu_b}, 32'h0);
    check("rst_alu_op", {26'h0, bus.o_alu_op}, 32'h0);
    check("rst_tx_data", {24'h0, bus.o_tx_data}, 32'h0);
    check("rst_outs", {28'h0, bus.o_tx_start, bus.o_busy, bus.o_overrun, bus.o_timeout}, 32'h0);

    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(vecs[i].exp_res);
      send_byte(vecs[i].a);
      send_byte(vecs[i].b);
      send_byte(vecs[i].op_byte);
      check($sformatf("v%0d_alu_a", i), {24'h0, bus.o_alu_a}, {24'h0, vecs[i].a});
      check($sformatf("v%0d_alu_b", i), {24'h0, bus.o_alu_b}, {24'h0, vecs[i].b});
      check($sformatf("v%0d_alu_op", i), {26'h0, bus.o_alu_op}, {26'h0, vecs[i].exp_op});
      expect_tx($sformatf("v%0d", i));
    end
    check("no_overrun", {31'h0, bus.o_overrun}, 32'h0);

    // Level-held rx_done: one byte only.
    @(negedge clk);
    bus.i_rx_data = 8'h11;
    bus.i_rx_done = 1'b1;
    repeat (50) @(negedge clk);
    bus.i_rx_done = 1'b0;
    check("lvl_alu_a", {24'h0, bus.o_alu_a}, 32'h11);
    check("lvl_busy", {31'h0, bus.o_busy}, 32'h0);
    exp_q.push_back(8'h33);
    send_byte(8'h22);
    send_byte(8'h20);
    check("lvl_alu_b", {24'h0, bus.o_alu_b}, 32'h22);
    expect_tx("lvl");

    // Byte arriving during WAIT_TX is dropped and flagged.
    exp_q.push_back(8'h33);
    send_byte(8'h30);
    send_byte(8'h03);
    send_byte(8'h20);
    repeat (2) @(negedge clk);
    send_byte(8'hAA);
    check("ovr_flag", {31'h0, bus.o_overrun}, 32'h1);
    check("ovr_tx_data", {24'h0, bus.o_tx_data}, 32'h33);
    check("ovr_alu_a", {24'h0, bus.o_alu_a}, 32'h30);
    check("ovr_busy", {31'h0, bus.o_busy}, 32'h1);
    bus.i_tx_done = 1'b1;
    @(negedge clk);
    bus.i_tx_done = 1'b0;
    check("ovr_busy_done", {31'h0, bus.o_busy}, 32'h0);
    exp_q.push_back(8'h0C);
    send_byte(8'h09);
    send_byte(8'h03);
    send_byte(8'h20);
    expect_tx("ovr_next");
    check("ovr_sticky", {31'h0, bus.o_overrun}, 32'h1);

    // Reset mid-command.
    send_byte(8'h7F);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mrst_alu_a", {24'h0, bus.o_alu_a}, 32'h0);
    check("mrst_alu_bop", {18'h0, bus.o_alu_b, bus.o_alu_op}, 32'h0);
    check("mrst_tx_data", {24'h0, bus.o_tx_data}, 32'h0);
    check("mrst_outs", {28'h0, bus.o_tx_start, bus.o_busy, bus.o_overrun, bus.o_timeout}, 32'h0);
    exp_q.push_back(8'h03);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h20);
    expect_tx("mrst");

    // Inter-byte idle after A.
    send_byte(8'h40);
    pulses = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.o_timeout === 1'b1) pulses++;
    end
    check("tmo_keep_a", {24'h0, bus.o_alu_a}, 32'h40);
`ifdef RX_TIMEOUT_EN
    check("tmo_pulses", pulses, 32'd1);
    exp_q.push_back(8'h08);
    send_byte(8'h09);
    send_byte(8'h01);
    send_byte(8'h22);
    check("tmo_new_a", {24'h0, bus.o_alu_a}, 32'h09);
    expect_tx("tmo");
`else
    check("tmo_pulses", pulses, 32'd0);
    exp_q.push_back(8'h42);
    send_byte(8'h02);
    send_byte(8'h20);
    check("tmo_alu_b", {24'h0, bus.o_alu_b}, 32'h02);
    expect_tx("tmo");
`endif

    repeat (3) @(negedge clk);
    check("sb_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_alu_if.md
Name: uart_alu_if

Overview:
- Downstream consumer of the UART receiver. Assembles three received bytes into an ALU command: operand A, operand B, opcode.
- Drives the ALU operand/opcode inputs and captures the ALU result.
- Hands the result to the UART transmitter with a start/done handshake.
- Sits between uart_rx/uart_tx and the combinational ALU in the TP2 top level.

Parameters:
- NB_DATA, 8, width of UART bytes, ALU operands and ALU result.
- NB_OP, 6, ALU opcode width; taken from the low NB_OP bits of the third byte.
- TIMEOUT_CYCLES, 1000000, clk cycles allowed between bytes of one command (used only with RX_TIMEOUT_EN).

Ports:
- clk  in  1  system clock
- i_rst  in  1  synchronous, active-high reset
- i_rx_data  in  NB_DATA  byte from receiver; valid when i_rx_done rises
- i_rx_done  in  1  receiver done flag; level-held, only its rising edge counts
- o_alu_a  out  NB_DATA  operand A to ALU
- o_alu_b  out  NB_DATA  operand B to ALU
- o_alu_op  out  NB_OP  opcode to ALU
- i_alu_result  in  NB_DATA  combinational ALU result
- o_tx_data  out  NB_DATA  byte to transmitter
- o_tx_start  out  1  one-cycle start pulse to transmitter
- i_tx_done  in  1  transmitter done; only its rising edge counts
- o_busy  out  1  high in EXEC, SEND, WAIT_TX
- o_overrun  out  1  sticky; byte arrived while busy
- o_timeout  out  1  one-cycle pulse on inter-byte timeout

Behaviour:
- Reset (sync, active-high, sampled at posedge clk): state=WAIT_A. All outputs 0. Edge-detect registers 0. Timeout counter 0. Reset dominates every other event, including mid-command and mid-transmit.
- Edge detect: rx_evt = i_rx_done & ~rx_done_d. tx_evt = i_tx_done & ~tx_done_d. Both delay registers update every cycle.
- WAIT_A: on rx_evt, o_alu_a <= i_rx_data, go to WAIT_B.
- WAIT_B: on rx_evt, o_alu_b <= i_rx_data, go to WAIT_OP.
- WAIT_OP: on rx_evt, o_alu_op <= i_rx_data[NB_OP-1:0], go to EXEC. Upper byte bits are discarded.
- EXEC: exactly one cycle (ALU settle). o_tx_data <= i_alu_result. Go to SEND.
- SEND: exactly one cycle. o_tx_start=1. Go to WAIT_TX.
- WAIT_TX: on tx_evt, go to WAIT_A. Waits indefinitely otherwise.
- Output timing: o_tx_start is registered and asserted in the 2nd cycle after the cycle in which the opcode rx_evt is detected. o_tx_start is never high for more than one cycle per command.
- o_alu_a/b/op hold their values until overwritten by the next command. They are not cleared on completion.
- rx_evt in EXEC/SEND/WAIT_TX: byte dropped, o_overrun <= 1 (cleared only by reset). State is unaffected.
- tx_evt outside WAIT_TX: ignored.
- o_busy is combinational from state.
- Widths: no arithmetic on data; opcode truncation as stated.

Optional Feature:
- Macro: RX_TIMEOUT_EN.
- Defined: a counter runs in WAIT_B and WAIT_OP. It clears on entry and on every rx_evt. When it reaches TIMEOUT_CYCLES-1 without an rx_evt:
  - state returns to WAIT_A, and the partial command is abandoned (o_alu_* keep their last values);
  - o_timeout pulses high for that one cycle.
  - If rx_evt and expiry occur in the same cycle, rx_evt wins and no timeout is raised.
- Undefined: no counter. WAIT_B and WAIT_OP wait indefinitely. o_timeout is tied 0.
- The port exists in both builds.

Test Plan:
- Nominal: bytes 0x05, 0x03, 0x20 (ADD), ALU model A+B. Expect o_alu_a=0x05, o_alu_b=0x03, o_alu_op=6'h20, then o_tx_data=0x08 with a single-cycle o_tx_start 2 cycles after the opcode edge. A tx_done rising edge returns o_busy to 0.
- Level-held done: i_rx_done stays high 50 cycles after byte 0x11. Only one byte is captured; the state advances only to WAIT_B.
- Overrun: send 4th byte 0xAA while in WAIT_TX. Expect o_overrun=1, o_tx_data unchanged, next command starts cleanly after tx_done.
- Opcode truncation: opcode byte 0xE2 gives o_alu_op=6'h22.
- Reset mid-command: after byte A=0x7F, assert i_rst for 1 cycle. Expect state WAIT_A, all outputs 0; the next three bytes 0x01, 0x02, 0x20 produce o_tx_data=0x03.
- RX_TIMEOUT_EN with TIMEOUT_CYCLES=16: send A only, then idle 16 cycles. Expect an o_timeout pulse and return to WAIT_A; the next 3 bytes form a complete command. Without the macro, the same stimulus leaves the state at WAIT_B.
